// File: rtl/lsu_pkg.sv
// Shared types, size codes and lane-mask helper for the load-store unit.
package lsu_pkg;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    // Enables for n bytes starting at lane ofs; lanes at or above 'bytes' fall off the bus.
    function automatic logic [7:0] lane_mask(input logic [3:0] ofs, input logic [3:0] n, input int bytes);
        logic [15:0] m;
        m = ((16'd1 << n) - 16'd1) << ofs;
        lane_mask = '0;
        for (int i = 0; i < 8; i++) begin
            lane_mask[i] = m[i] && (i < bytes);
        end
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store data shifted into beat lanes, load bytes merged and extended.
module lsu_align
    import lsu_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int BYTES = XLEN / 8,
    localparam int OFS_W = $clog2(BYTES)
) (
    input  logic [OFS_W-1:0] ofs_i,
    input  logic [1:0]       size_i,
    input  logic             signed_i,
    input  logic             split_i,
    input  logic [XLEN-1:0]  wdata_i,
    input  logic [XLEN-1:0]  lo_i,
    input  logic [XLEN-1:0]  hi_i,
    output logic [XLEN-1:0]  wlane0_o,
    output logic [XLEN-1:0]  wlane1_o,
    output logic [XLEN-1:0]  rdata_o
);

    localparam int SH_W = OFS_W + 4;

    logic [SH_W-1:0] shLo;
    logic [SH_W-1:0] shHi;
    logic [XLEN-1:0] raw;
    logic [3:0]      n;
    logic            sbit;

    // A shift by a full XLEN (ofs == 0) yields zero, which is what the unused second beat wants.
    always_comb begin
        shLo = SH_W'(ofs_i) << 3;
        shHi = SH_W'(XLEN) - shLo;
        n = 4'd1;
        case (size_i)
            SIZE_B: n = 4'd1;
            SIZE_H: n = 4'd2;
            SIZE_W: n = 4'd4;
            SIZE_D: n = 4'd8;
        endcase
        wlane0_o = wdata_i << shLo;
        wlane1_o = wdata_i >> shHi;
        raw = (lo_i >> shLo) | (split_i ? (hi_i << shHi) : '0);
        sbit = 1'b0;
        for (int i = 0; i < BYTES; i++) begin
            if (4'(i) + 4'd1 == n) sbit = signed_i & raw[8*i+7];
        end
        rdata_o = '0;
        for (int i = 0; i < BYTES; i++) begin
            rdata_o[8*i +: 8] = (4'(i) < n) ? raw[8*i +: 8] : {8{sbit}};
        end
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load-store unit: one core request at a time, split into one or two word-aligned bus beats.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter bit SPLIT_MISALIGNED = 1'b1,
    parameter int TIMEOUT_CYCLES   = 0,
    parameter int TO_W             = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic              req_wen,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              bus_reqValid,
    output logic [XLEN-1:0]   bus_addr,
    output logic [1:0]        bus_size,
    output logic              bus_wen,
    output logic [XLEN-1:0]   bus_wdata,
    output logic [XLEN/8-1:0] bus_wmask,
    input  logic              bus_respValid,
    input  logic [XLEN-1:0]   bus_rdata
);

    localparam int BYTES = XLEN / 8;
    localparam int OFS_W = $clog2(BYTES);
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

    state_t            state_q;
    logic [XLEN-1:0]   addr_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic              wen_q;
    logic [XLEN-1:0]   wdata_q;
    logic              cross_q;
    logic [XLEN-1:0]   rdata0_q;
    logic [TO_W-1:0]   cnt_q;
    logic              req_ready_q;
    logic              resp_valid_q;
    logic [XLEN-1:0]   resp_rdata_q;
    logic              resp_err_q;
    logic              bus_reqValid_q;
    logic [XLEN-1:0]   bus_addr_q;
    logic [1:0]        bus_size_q;
    logic              bus_wen_q;
    logic [XLEN-1:0]   bus_wdata_q;
    logic [BYTES-1:0]  bus_wmask_q;

    logic [OFS_W-1:0]  ofsIn;
    logic [3:0]        nIn;
    logic [3:0]        nQ;
    logic              crossIn;
    logic              errIn;
    logic              accept;
    logic              timeoutHit;
    logic [XLEN-1:0]   alignedIn;
    logic [XLEN-1:0]   beat1Addr;
    logic [BYTES-1:0]  mask0;
    logic [BYTES-1:0]  mask1;
    logic [XLEN-1:0]   wlane0;
    logic [XLEN-1:0]   wlane1;
    logic [XLEN-1:0]   loadData;

    // While idle the aligner sees the incoming request so beat-0 lanes can be registered at accept.
    always_comb begin
        ofsIn      = req_addr[OFS_W-1:0];
        nIn        = 4'd1 << req_size;
        nQ         = 4'd1 << size_q;
        crossIn    = ({1'b0, 4'(ofsIn)} + {1'b0, nIn}) > 5'(BYTES);
        errIn      = (nIn > 4'(BYTES)) || (crossIn && !SPLIT_MISALIGNED);
        accept     = req_valid && req_ready_q;
        timeoutHit = TO_EN && (cnt_q == TO_LAST);
        alignedIn  = req_addr & ~XLEN'(BYTES - 1);
        beat1Addr  = (addr_q & ~XLEN'(BYTES - 1)) + XLEN'(BYTES);
        mask0      = BYTES'(lane_mask(4'(ofsIn), nIn, BYTES));
        mask1      = BYTES'(lane_mask(4'd0, 4'(addr_q[OFS_W-1:0]) + nQ - 4'(BYTES), BYTES));
    end

    lsu_align #(.XLEN(XLEN)) u_align (
        .ofs_i    ((state_q == IDLE) ? ofsIn : addr_q[OFS_W-1:0]),
        .size_i   ((state_q == IDLE) ? req_size : size_q),
        .signed_i (signed_q),
        .split_i  (state_q == BEAT1),
        .wdata_i  ((state_q == IDLE) ? req_wdata : wdata_q),
        .lo_i     ((state_q == BEAT1) ? rdata0_q : bus_rdata),
        .hi_i     (bus_rdata),
        .wlane0_o (wlane0),
        .wlane1_o (wlane1),
        .rdata_o  (loadData)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            size_q         <= '0;
            signed_q       <= 1'b0;
            wen_q          <= 1'b0;
            wdata_q        <= '0;
            cross_q        <= 1'b0;
            rdata0_q       <= '0;
            cnt_q          <= '0;
            req_ready_q    <= 1'b1;
            resp_valid_q   <= 1'b0;
            resp_rdata_q   <= '0;
            resp_err_q     <= 1'b0;
            bus_reqValid_q <= 1'b0;
            bus_addr_q     <= '0;
            bus_size_q     <= '0;
            bus_wen_q      <= 1'b0;
            bus_wdata_q    <= '0;
            bus_wmask_q    <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q      <= req_addr;
                        size_q      <= req_size;
                        signed_q    <= req_signed;
                        wen_q       <= req_wen;
                        wdata_q     <= req_wdata;
                        cross_q     <= crossIn;
                        cnt_q       <= '0;
                        req_ready_q <= 1'b0;
                        if (errIn) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else begin
                            state_q        <= BEAT0;
                            bus_reqValid_q <= 1'b1;
                            bus_addr_q     <= alignedIn;
                            bus_size_q     <= crossIn ? 2'(OFS_W) : req_size;
                            bus_wen_q      <= req_wen;
                            bus_wdata_q    <= wlane0;
                            bus_wmask_q    <= mask0;
                        end
                    end
                end
                BEAT0, BEAT1: begin
                    // A response in the same cycle as the timeout still completes the beat.
                    if (bus_respValid) begin
                        cnt_q <= '0;
                        if (state_q == BEAT0) rdata0_q <= bus_rdata;
                        if (state_q == BEAT0 && cross_q) begin
                            state_q     <= BEAT1;
                            bus_addr_q  <= beat1Addr;
                            bus_wdata_q <= wlane1;
                            bus_wmask_q <= mask1;
                        end else begin
                            state_q        <= RESP;
                            bus_reqValid_q <= 1'b0;
                            resp_valid_q   <= 1'b1;
                            resp_err_q     <= 1'b0;
                            resp_rdata_q   <= wen_q ? '0 : loadData;
                        end
                    end else if (timeoutHit) begin
                        state_q        <= RESP;
                        bus_reqValid_q <= 1'b0;
                        resp_valid_q   <= 1'b1;
                        resp_err_q     <= 1'b1;
                        resp_rdata_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + TO_W'(1);
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready    = req_ready_q;
    assign resp_valid   = resp_valid_q;
    assign resp_rdata   = resp_rdata_q;
    assign resp_err     = resp_err_q;
    assign bus_reqValid = bus_reqValid_q;
    assign bus_addr     = bus_addr_q;
    assign bus_size     = bus_size_q;
    assign bus_wen      = bus_wen_q;
    assign bus_wdata    = bus_wdata_q;
    assign bus_wmask    = bus_wmask_q;

endmodule
